// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package cpu_pkg;

  localparam int unsigned FETCH_W = 13;
  localparam int unsigned FIELD_W = 4;

  // Bit positions of the fields inside a memory frame {a, b, c, op}.
  localparam int unsigned A_MSB  = 12;
  localparam int unsigned B_MSB  = 8;
  localparam int unsigned C_BIT  = 4;
  localparam int unsigned OP_MSB = 3;

  localparam logic [FIELD_W-1:0] OP_INC = 4'b0000;
  localparam logic [FIELD_W-1:0] OP_ADD = 4'b0001;
  localparam logic [FIELD_W-1:0] OP_SUB = 4'b0010;
  localparam logic [FIELD_W-1:0] OP_AND = 4'b0100;
  localparam logic [FIELD_W-1:0] OP_NOT = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    ISSUE,
    ADVANCE,
    DONE
  } state_e;

  // True for opcodes the ALU implements.
  function automatic logic op_is_legal(input logic [FIELD_W-1:0] op);
    case (op)
      OP_INC, OP_ADD, OP_SUB, OP_AND, OP_NOT: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_seq_frame_decode.sv
// Splits a memory frame into ALU fields and flags whether the opcode is legal.
module frame_decode
  import cpu_pkg::*;
(
  input  logic [FETCH_W-1:0] frame_i,
  output logic [FIELD_W-1:0] a_c,
  output logic [FIELD_W-1:0] b_c,
  output logic               c_c,
  output logic [FIELD_W-1:0] op_c,
  output logic               op_legal_c
);

  assign a_c        = frame_i[A_MSB -: FIELD_W];
  assign b_c        = frame_i[B_MSB -: FIELD_W];
  assign c_c        = frame_i[C_BIT];
  assign op_c       = frame_i[OP_MSB -: FIELD_W];
  assign op_legal_c = op_is_legal(op_c);

endmodule

// File: rtl/instr_fetch_seq.sv
// Walks program addresses 0..LAST_ADDR, captures each memory frame and issues
// legal instructions to the ALU over a valid/ready handshake.
module instr_fetch_seq
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned LAST_ADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [FETCH_W-1:0] mem_data,
  output logic [FIELD_W-1:0] a_out,
  output logic [FIELD_W-1:0] b_out,
  output logic               c_out,
  output logic [FIELD_W-1:0] op_out,
  output logic               op_valid,
  input  logic               op_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               err_q, err_d;
  logic [FIELD_W-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic               c_q, c_d;
  logic               mem_en_q, mem_en_d;
  logic               op_valid_q, op_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [FIELD_W-1:0] dec_a_c, dec_b_c, dec_op_c;
  logic               dec_c_c, dec_legal_c;

  frame_decode u_frame_decode (
    .frame_i    (mem_data),
    .a_c        (dec_a_c),
    .b_c        (dec_b_c),
    .c_c        (dec_c_c),
    .op_c       (dec_op_c),
    .op_legal_c (dec_legal_c)
  );

  // Next state, pc, capture registers and registered status outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    op_d    = op_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
          err_d   = 1'b0;
        end
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        a_d  = dec_a_c;
        b_d  = dec_b_c;
        c_d  = dec_c_c;
        op_d = dec_op_c;
        if (dec_legal_c) begin
          state_d = ISSUE;
        end else begin
          err_d   = 1'b1;
          state_d = ADVANCE;
        end
      end
      ISSUE: begin
        if (op_valid_q && op_ready) state_d = ADVANCE;
      end
      ADVANCE: begin
        if (pc_q == LAST_PC) begin
          state_d = DONE;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are decoded from the upcoming state so they register cleanly.
    mem_en_d   = (state_d == FETCH);
    op_valid_d = (state_d == ISSUE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      err_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      op_q       <= '0;
      mem_en_q   <= 1'b0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      op_q       <= op_d;
      mem_en_q   <= mem_en_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_addr = pc_q;
  assign a_out    = a_q;
  assign b_out    = b_q;
  assign c_out    = c_q;
  assign op_out   = op_q;
  assign op_valid = op_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq with a 1-cycle registered-read memory model.
module tb_instr_fetch_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, start2 = 1'b0;
  logic op_ready = 1'b1;
  logic op_ready2 = 1'b1;

  logic        mem_en, op_valid, busy, done, err, c_out;
  logic [2:0]  mem_addr;
  logic [12:0] mem_data;
  logic [3:0]  a_out, b_out, op_out;

  logic        mem_en2, op_valid2, busy2, done2, err2, c_out2;
  logic [2:0]  mem_addr2;
  logic [12:0] mem_data2;
  logic [3:0]  a_out2, b_out2, op_out2;

  instr_fetch_seq #(.ADDR_W(3), .LAST_ADDR(5)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .a_out(a_out), .b_out(b_out), .c_out(c_out), .op_out(op_out),
    .op_valid(op_valid), .op_ready(op_ready), .busy(busy), .done(done), .err(err)
  );

  instr_fetch_seq #(.ADDR_W(3), .LAST_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start2), .mem_en(mem_en2), .mem_addr(mem_addr2),
    .mem_data(mem_data2), .a_out(a_out2), .b_out(b_out2), .c_out(c_out2), .op_out(op_out2),
    .op_valid(op_valid2), .op_ready(op_ready2), .busy(busy2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  // Program image, one field per array.
  logic [3:0] pa [0:7];
  logic [3:0] pb [0:7];
  logic       pcr [0:7];
  logic [3:0] pop [0:7];

  always @(posedge clk) begin
    if (mem_en)  mem_data  <= {pa[mem_addr],  pb[mem_addr],  pcr[mem_addr],  pop[mem_addr]};
    if (mem_en2) mem_data2 <= {pa[mem_addr2], pb[mem_addr2], pcr[mem_addr2], pop[mem_addr2]};
  end

  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int done_cnt = 0, done_rel = -1;
  int done2_cnt = 0, done2_rel = -1;

  typedef struct {
    int addr;
    int a;
    int b;
    int c;
    int op;
    int cyc;
  } exp_t;

  exp_t fq[$], iq[$], fq2[$], iq2[$];

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc - start_cyc);
    end
  endtask

  task automatic fail(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: got %0d, nothing expected (cycle %0d)", name, act, cyc - start_cyc);
  endtask

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0111};
  endfunction

  // Pushes expected fetches/issues with hand-derived cycle numbers; returns DONE cycle.
  function automatic int plan(input int last, input int stall_addr, input int stall, input bit second);
    int t;
    t = 1;
    for (int k = 0; k <= last; k++) begin
      exp_t e;
      int   s;
      s      = (k == stall_addr) ? stall : 0;
      e.addr = k;
      e.a    = int'(pa[k]);
      e.b    = int'(pb[k]);
      e.c    = int'(pcr[k]);
      e.op   = int'(pop[k]);
      e.cyc  = t;
      if (second) fq2.push_back(e); else fq.push_back(e);
      if (legal(pop[k])) begin
        e.cyc = t + 2 + s;
        if (second) iq2.push_back(e); else iq.push_back(e);
        t += 4 + s;
      end else begin
        t += 3;
      end
    end
    return t;
  endfunction

  // Monitor for the LAST_ADDR=5 instance.
  always @(negedge clk) begin
    exp_t e;
    int   rel;
    rel = cyc - start_cyc;
    if (!rst) begin
      if (mem_en) begin
        if (fq.size() == 0) fail("fetch_unexpected_addr", int'(mem_addr));
        else begin
          e = fq.pop_front();
          chk("fetch_addr", int'(mem_addr), e.addr);
          chk("fetch_cycle", rel, e.cyc);
        end
      end
      if (op_valid) begin
        if (iq.size() == 0) fail("issue_unexpected_op", int'(op_out));
        else begin
          e = iq[0];
          chk("issue_a", int'(a_out), e.a);
          chk("issue_b", int'(b_out), e.b);
          chk("issue_c", int'(c_out), e.c);
          chk("issue_op", int'(op_out), e.op);
          if (op_ready) begin
            void'(iq.pop_front());
            chk("issue_cycle", rel, e.cyc);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
    end
  end

  // Monitor for the LAST_ADDR=0 instance.
  always @(negedge clk) begin
    exp_t e;
    int   rel;
    rel = cyc - start_cyc;
    if (!rst) begin
      if (mem_en2) begin
        if (fq2.size() == 0) fail("l0_fetch_unexpected_addr", int'(mem_addr2));
        else begin
          e = fq2.pop_front();
          chk("l0_fetch_addr", int'(mem_addr2), e.addr);
          chk("l0_fetch_cycle", rel, e.cyc);
        end
      end
      if (op_valid2) begin
        if (iq2.size() == 0) fail("l0_issue_unexpected_op", int'(op_out2));
        else begin
          e = iq2.pop_front();
          chk("l0_issue_a", int'(a_out2), e.a);
          chk("l0_issue_b", int'(b_out2), e.b);
          chk("l0_issue_c", int'(c_out2), e.c);
          chk("l0_issue_op", int'(op_out2), e.op);
          chk("l0_issue_cycle", rel, e.cyc);
        end
      end
      if (done2) begin
        done2_cnt++;
        done2_rel = rel;
      end
    end
  end

  // Advance n cycles; inputs change 2 time units after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One-cycle start pulse; the sampling edge defines cycle 0.
  task automatic do_start(input bit second);
    start_cyc = cyc;
    if (second) start2 = 1'b1; else start = 1'b1;
    step(1);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < limit) begin
      step(1);
      n++;
    end
    if (done_cnt == d0) fail("done_timeout", n);
  endtask

  task automatic finish_run(input string tag, input int want_done);
    wait_done(80);
    chk({tag, "_done_cycle"}, done_rel, want_done);
    chk({tag, "_busy_after_done"}, int'(busy), 0);
    chk({tag, "_fetch_q_left"}, fq.size(), 0);
    chk({tag, "_issue_q_left"}, iq.size(), 0);
  endtask

  task automatic load_default();
    pa[0] = 4'd2;  pb[0] = 4'd8;  pcr[0] = 1'b1; pop[0] = 4'b0000;
    pa[1] = 4'd2;  pb[1] = 4'd7;  pcr[1] = 1'b0; pop[1] = 4'b0001;
    pa[2] = 4'd3;  pb[2] = 4'd3;  pcr[2] = 1'b0; pop[2] = 4'b0010;
    pa[3] = 4'd5;  pb[3] = 4'd9;  pcr[3] = 1'b1; pop[3] = 4'b0100;
    pa[4] = 4'd15; pb[4] = 4'd1;  pcr[4] = 1'b0; pop[4] = 4'b0111;
    pa[5] = 4'd1;  pb[5] = 4'd14; pcr[5] = 1'b1; pop[5] = 4'b0001;
    pa[6] = 4'd0;  pb[6] = 4'd0;  pcr[6] = 1'b0; pop[6] = 4'b0000;
    pa[7] = 4'd0;  pb[7] = 4'd0;  pcr[7] = 1'b0; pop[7] = 4'b0000;
  endtask

  initial begin
    int t_done, d_before;
    load_default();
    #1 rst = 1'b1;
    #2;
    chk("rst_op_valid", int'(op_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_fields", int'({a_out, b_out, c_out, op_out}), 0);
    step(2);
    rst = 1'b0;
    step(2);

    // 1: straight run, ready always high.
    t_done = plan(5, -1, 0, 1'b0);
    do_start(1'b0);
    finish_run("t1", t_done);
    chk("t1_done_pulses", done_cnt, 1);

    // 2: stall addr 1 for five ISSUE cycles; ready low outside ISSUE is harmless.
    t_done = plan(5, 1, 5, 1'b0);
    do_start(1'b0);
    step(3);
    op_ready = 1'b0;
    step(8);
    chk("t2_stalled_valid", int'(op_valid), 1);
    chk("t2_stalled_addr", int'(mem_addr), 1);
    op_ready = 1'b1;
    finish_run("t2", t_done);

    // 3: illegal opcode at addr 2 sets sticky err and skips that issue.
    pa[2] = 4'd0; pb[2] = 4'd0; pcr[2] = 1'b0; pop[2] = 4'b1111;
    t_done = plan(5, -1, 0, 1'b0);
    do_start(1'b0);
    step(9);
    chk("t3_err_before_capture", int'(err), 0);
    step(1);
    chk("t3_err_after_capture", int'(err), 1);
    chk("t3_no_valid_illegal", int'(op_valid), 0);
    finish_run("t3", t_done);
    chk("t3_err_after_done", int'(err), 1);
    load_default();

    // 4: start while busy at addr 3 is ignored; accepted start clears err.
    d_before = done_cnt;
    t_done = plan(5, -1, 0, 1'b0);
    do_start(1'b0);
    chk("t4_err_cleared", int'(err), 0);
    step(12);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t4_pc_unchanged", int'(mem_addr), 3);
    finish_run("t4", t_done);
    chk("t4_done_pulses", done_cnt - d_before, 1);

    // 5: start right after DONE is accepted; reset mid-ISSUE at addr 4.
    t_done = plan(5, -1, 0, 1'b0);
    do_start(1'b0);
    step(18);
    chk("t5_valid_before_rst", int'(op_valid), 1);
    chk("t5_a_before_rst", int'(a_out), 15);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_op_valid", int'(op_valid), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_mem_en", int'(mem_en), 0);
    chk("t5_rst_mem_addr", int'(mem_addr), 0);
    chk("t5_rst_fields", int'({a_out, b_out, c_out, op_out}), 0);
    fq.delete();
    iq.delete();
    step(2);
    rst = 1'b0;
    step(1);
    t_done = plan(5, -1, 0, 1'b0);
    do_start(1'b0);
    finish_run("t5", t_done);

    // 6: LAST_ADDR=0 instance processes address 0 only.
    d_before = done_cnt;
    t_done = plan(0, -1, 0, 1'b1);
    do_start(1'b1);
    begin
      int n;
      n = 0;
      while (done2_cnt == 0 && n < 40) begin
        step(1);
        n++;
      end
      if (done2_cnt == 0) fail("l0_done_timeout", n);
    end
    step(6);
    chk("l0_done_cycle", done2_rel, t_done);
    chk("l0_done_pulses", done2_cnt, 1);
    chk("l0_busy_after", int'(busy2), 0);
    chk("l0_fetch_q_left", fq2.size(), 0);
    chk("l0_issue_q_left", iq2.size(), 0);
    chk("l0_main_idle", done_cnt - d_before, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
